enc_scan_display: RTL and testbench

Parametrised successor to the two-encoder display path: N-channel up/down counter bank plus a paged, time-multiplexed 7-segment digit scanner with anti-ghosting blanking. Sits between the `encoder` instances (single-cycle `cw`/`ccw` pulses) and the existing `decode2`/`decode7` drivers. Adds selectable binary/BCD counting, saturate-or-wrap, per-channel clear, and paging when channels exceed display digits.

---
 rtl/enc_disp_pkg.sv | 61 ++++++
 rtl/enc_counter.sv | 67 ++++++
 rtl/enc_scan_display.sv | 129 ++++++++++++
 tb/tb_enc_scan_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_disp_pkg.sv
// enc_disp_pkg
//   Shared types and helpers for the encoder counter bank and the paged
//   7-segment digit scanner.
//   - nib_res_t     : one nibble step result (next nibble + carry/borrow out)
//   - nibble_step() : +1/-1 on a single nibble, binary or decimal
//   - calc_dpc / calc_cpp / calc_num_pages / width_of : derived constants
package enc_disp_pkg;

    typedef struct packed {
        logic [3:0] nib;
        logic       carry;
    } nib_res_t;

    // Steps one nibble up or down. carry is set when the nibble wraps
    // (F->0 / 9->0 going up, 0->F / 0->9 going down) so the caller can
    // ripple into the next nibble. A decimal nibble above 9 is treated as 9.
    function automatic nib_res_t nibble_step(input logic [3:0] nib,
                                             input logic       up,
                                             input logic       bcd);
        nib_res_t r;
        r.nib   = nib;
        r.carry = 1'b0;
        if (up) begin
            if ((bcd && (nib >= 4'd9)) || (!bcd && (nib == 4'hF))) begin
                r.nib   = 4'd0;
                r.carry = 1'b1;
            end else begin
                r.nib = nib + 4'd1;
            end
        end else begin
            if (nib == 4'd0) begin
                r.nib   = bcd ? 4'd9 : 4'hF;
                r.carry = 1'b1;
            end else begin
                r.nib = nib - 4'd1;
            end
        end
        return r;
    endfunction

    // Digits per channel.
    function automatic int calc_dpc(input int count_w);
        return count_w / 4;
    endfunction

    // Channels shown on one page.
    function automatic int calc_cpp(input int digits, input int dpc);
        return digits / dpc;
    endfunction

    // Number of pages needed to show every channel.
    function automatic int calc_num_pages(input int num_ch, input int cpp);
        return (num_ch + cpp - 1) / cpp;
    endfunction

    // Index width for n values, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_counter.sv
// enc_counter
//   One channel of the up/down counter bank.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     cw, ccw    : single-cycle increment / decrement pulses
//     clr        : synchronous clear (highest priority)
//     count      : current count, COUNT_W bits (nibble 0 = LS)
//   BCD selects decimal nibbles, SAT selects saturate instead of wrap.
module enc_counter
    import enc_disp_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int BCD     = 1,
    parameter int SAT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cw,
    input  logic               ccw,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    localparam int DPC = calc_dpc(COUNT_W);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] stepped;
    logic               ripple;
    nib_res_t           res;

    always_comb begin
        stepped = count_q;
        ripple  = 1'b1;
        res     = '0;
        // Ripple the +1/-1 from nibble 0 upward; a carry out of the top
        // nibble means the count passed max (up) or min (down).
        for (int i = 0; i < DPC; i++) begin
            if (ripple) begin
                res                = nibble_step(count_q[i*4 +: 4], cw, (BCD != 0));
                stepped[i*4 +: 4]  = res.nib;
                ripple             = res.carry;
            end
        end

        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (cw ^ ccw) begin
            // Full wrap already yields 0 (up) or max (down); saturation
            // simply refuses the overflowing step.
            if (!(ripple && (SAT != 0))) begin
                count_d = stepped;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/enc_scan_display.sv
// enc_scan_display
//   N-channel encoder counter bank feeding a paged, time-multiplexed
//   7-segment scanner with a blanking window at the start of each slot.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     cw, ccw     : per-channel increment / decrement pulses
//     clr         : per-channel synchronous clear
//     page_next   : request to advance the page at the next frame wrap
//     digit       : active digit index (to decode2)
//     disp_digit  : nibble for the active digit (to decode7)
//     blank       : 1 = all segments off
//     page        : current page
//     counts      : flattened counts, channel k at [k*COUNT_W +: COUNT_W]
module enc_scan_display
    import enc_disp_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 8,
    parameter int DIGITS       = 4,
    parameter int DIV_BITS     = 16,
    parameter int BLANK_CYCLES = 64,
    parameter int BCD          = 1,
    parameter int SAT          = 0,
    localparam int DPC         = calc_dpc(COUNT_W),
    localparam int CPP         = calc_cpp(DIGITS, DPC),
    localparam int NUM_PAGES   = calc_num_pages(NUM_CH, CPP),
    localparam int DIG_W       = width_of(DIGITS),
    localparam int PG_W        = width_of(NUM_PAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         cw,
    input  logic [NUM_CH-1:0]         ccw,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      page_next,
    output logic [DIG_W-1:0]          digit,
    output logic [3:0]                disp_digit,
    output logic                      blank,
    output logic [PG_W-1:0]           page,
    output logic [NUM_CH*COUNT_W-1:0] counts
);

    logic [DIV_BITS-1:0] div_q, div_d;
    logic                wrap_q, wrap_d;
    logic [DIG_W-1:0]    digit_q, digit_d;
    logic [PG_W-1:0]     page_q, page_d;
    logic                pend_q, pend_d;
    logic [3:0]          disp_q, disp_d;
    logic                blank_q, blank_d;
    int                  ch_idx;
    int                  nib_idx;
    logic                chan_ok;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        enc_counter #(
            .COUNT_W (COUNT_W),
            .BCD     (BCD),
            .SAT     (SAT)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .cw    (cw[k]),
            .ccw   (ccw[k]),
            .clr   (clr[k]),
            .count (counts[k*COUNT_W +: COUNT_W])
        );
    end

    always_comb begin
        div_d   = div_q + DIV_BITS'(1);
        // wrap_q marks the clock after the divider rolled over, which is
        // when the digit steps; out of reset it is clear so slot 0 gets a
        // full-length first slot.
        wrap_d  = (div_q == '1);
        digit_d = digit_q;
        page_d  = page_q;
        pend_d  = pend_q | page_next;

        if (wrap_q) begin
            if (digit_q == DIG_W'(DIGITS - 1)) begin
                digit_d = '0;
                // Page changes only at frame wrap, so a frame never mixes
                // pages; any number of requests collapse into one step.
                if (pend_d) begin
                    page_d = (page_q == PG_W'(NUM_PAGES - 1)) ? '0 : page_q + PG_W'(1);
                end
                pend_d = 1'b0;
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end

        // Outputs are registered, so select using the next digit/page.
        ch_idx  = int'(page_d) * CPP + int'(digit_d) / DPC;
        nib_idx = int'(digit_d) % DPC;
        chan_ok = (ch_idx < NUM_CH);
        disp_d  = 4'd0;
        if (chan_ok) begin
            disp_d = counts[ch_idx*COUNT_W + nib_idx*4 +: 4];
        end
        blank_d = (div_q < DIV_BITS'(BLANK_CYCLES)) || !chan_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            wrap_q  <= 1'b0;
            digit_q <= '0;
            page_q  <= '0;
            pend_q  <= 1'b0;
            disp_q  <= 4'd0;
            blank_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            wrap_q  <= wrap_d;
            digit_q <= digit_d;
            page_q  <= page_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            blank_q <= blank_d;
        end
    end

    assign digit      = digit_q;
    assign page       = page_q;
    assign disp_digit = disp_q;
    assign blank      = blank_q;

endmodule

// File: tb/tb_enc_scan_display.sv
// tb_enc_scan_display
//   Directed bench for enc_scan_display. Four instances share stimulus:
//     a: BCD wrap, b: BCD saturate, c: binary wrap (all 4 channels),
//     d: BCD wrap with 3 channels (two pages, second page half empty).
module tb_enc_scan_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cw = '0, ccw = '0, clr = '0;
    logic       page_next = 1'b0;

    logic [1:0]  digit_a, digit_b, digit_c, digit_d;
    logic [3:0]  disp_a, disp_b, disp_c, disp_d;
    logic        blank_a, blank_b, blank_c, blank_d;
    logic [0:0]  page_a, page_b, page_c, page_d;
    logic [31:0] counts_a, counts_b, counts_c;
    logic [23:0] counts_d;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    enc_scan_display #(.NUM_CH(4), .DIV_BITS(4), .BLANK_CYCLES(2), .BCD(1), .SAT(0)) dut_a (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .clr(clr), .page_next(page_next),
        .digit(digit_a), .disp_digit(disp_a), .blank(blank_a), .page(page_a), .counts(counts_a));
    enc_scan_display #(.NUM_CH(4), .DIV_BITS(4), .BLANK_CYCLES(2), .BCD(1), .SAT(1)) dut_b (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .clr(clr), .page_next(page_next),
        .digit(digit_b), .disp_digit(disp_b), .blank(blank_b), .page(page_b), .counts(counts_b));
    enc_scan_display #(.NUM_CH(4), .DIV_BITS(4), .BLANK_CYCLES(2), .BCD(0), .SAT(0)) dut_c (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .clr(clr), .page_next(page_next),
        .digit(digit_c), .disp_digit(disp_c), .blank(blank_c), .page(page_c), .counts(counts_c));
    enc_scan_display #(.NUM_CH(3), .DIV_BITS(4), .BLANK_CYCLES(2), .BCD(1), .SAT(0)) dut_d (
        .clk(clk), .reset(reset), .cw(cw[2:0]), .ccw(ccw[2:0]), .clr(clr[2:0]), .page_next(page_next),
        .digit(digit_d), .disp_digit(disp_d), .blank(blank_d), .page(page_d), .counts(counts_d));

    task automatic pulse(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] cl);
        @(negedge clk);
        cw = up; ccw = dn; clr = cl;
        @(negedge clk);
        cw = '0; ccw = '0; clr = '0;
    endtask

    task automatic pulse_page();
        @(negedge clk);
        page_next = 1'b1;
        @(negedge clk);
        page_next = 1'b0;
    endtask

    // Waits at negedges for dut_a (sel 0) or dut_d (sel 1) to show digit d,
    // optionally also requiring the blank window to be over.
    task automatic wait_digit(input int sel, input int d, input bit unblanked, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sel == 0 && int'(digit_a) == d && (!unblanked || !blank_a)) begin ok = 1'b1; break; end
            if (sel == 1 && int'(digit_d) == d && (!unblanked || !blank_d)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_leave_d(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(digit_d) != d) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (counts_a !== 32'h0) begin errs++; $display("FAIL reset_counts got %h want 0", counts_a); end
        vec++; if (digit_a !== 2'd0) begin errs++; $display("FAIL reset_digit got %0d want 0", digit_a); end
        vec++; if (disp_a !== 4'd0) begin errs++; $display("FAIL reset_disp got %0d want 0", disp_a); end
        vec++; if (blank_a !== 1'b1) begin errs++; $display("FAIL reset_blank got %b want 1", blank_a); end
        vec++; if (page_d !== 1'b0) begin errs++; $display("FAIL reset_page got %0d want 0", page_d); end
        reset = 1'b0;
    endtask

    task automatic test_bcd_count();
        bit ok;
        for (int i = 0; i < 20; i++) pulse(4'b0001, 4'b0000, 4'b0000);
        vec++; if (counts_a[7:0] !== 8'h20) begin errs++; $display("FAIL bcd_20 got %h want 20", counts_a[7:0]); end
        vec++; if (counts_c[7:0] !== 8'h14) begin errs++; $display("FAIL bin_20 got %h want 14", counts_c[7:0]); end
        wait_digit(0, 1, 1'b1, ok);
        vec++; if (!ok || disp_a !== 4'd2) begin errs++; $display("FAIL slot1_disp got %0d ok=%0d want 2", disp_a, ok); end
        wait_digit(0, 0, 1'b1, ok);
        vec++; if (!ok || disp_a !== 4'd0) begin errs++; $display("FAIL slot0_disp got %0d ok=%0d want 0", disp_a, ok); end
        pulse(4'b0000, 4'b0001, 4'b0000);
        vec++; if (counts_a[7:0] !== 8'h19) begin errs++; $display("FAIL bcd_borrow got %h want 19", counts_a[7:0]); end
        vec++; if (counts_c[7:0] !== 8'h13) begin errs++; $display("FAIL bin_dec got %h want 13", counts_c[7:0]); end
    endtask

    task automatic test_wrap_sat();
        pulse(4'b0000, 4'b0010, 4'b0000);
        vec++; if (counts_a[15:8] !== 8'h99) begin errs++; $display("FAIL bcd_wrap_dn got %h want 99", counts_a[15:8]); end
        vec++; if (counts_b[15:8] !== 8'h00) begin errs++; $display("FAIL bcd_sat_dn got %h want 00", counts_b[15:8]); end
        vec++; if (counts_c[15:8] !== 8'hFF) begin errs++; $display("FAIL bin_wrap_dn got %h want FF", counts_c[15:8]); end
        pulse(4'b0010, 4'b0000, 4'b0000);
        vec++; if (counts_a[15:8] !== 8'h00) begin errs++; $display("FAIL bcd_wrap_up got %h want 00", counts_a[15:8]); end
        vec++; if (counts_b[15:8] !== 8'h01) begin errs++; $display("FAIL bcd_sat_up got %h want 01", counts_b[15:8]); end
        vec++; if (counts_c[15:8] !== 8'h00) begin errs++; $display("FAIL bin_wrap_up got %h want 00", counts_c[15:8]); end
    endtask

    task automatic test_binary_prio();
        pulse(4'b0000, 4'b0100, 4'b0000);
        vec++; if (counts_c[23:16] !== 8'hFF) begin errs++; $display("FAIL bin_ff got %h want FF", counts_c[23:16]); end
        // ch2 up, ch3 gets both pulses at once
        pulse(4'b1100, 4'b1000, 4'b0000);
        vec++; if (counts_c[23:16] !== 8'h00) begin errs++; $display("FAIL bin_ff_wrap got %h want 00", counts_c[23:16]); end
        vec++; if (counts_c[31:24] !== 8'h00) begin errs++; $display("FAIL both_pulses got %h want 00", counts_c[31:24]); end
        vec++; if (counts_b[23:16] !== 8'h01) begin errs++; $display("FAIL sat_recover got %h want 01", counts_b[23:16]); end
        pulse(4'b0100, 4'b0000, 4'b0000);
        vec++; if (counts_c[23:16] !== 8'h01) begin errs++; $display("FAIL bin_inc got %h want 01", counts_c[23:16]); end
        pulse(4'b0100, 4'b0000, 4'b0100);
        vec++; if (counts_c[23:16] !== 8'h00) begin errs++; $display("FAIL clr_prio got %h want 00", counts_c[23:16]); end
        vec++; if (counts_b[23:16] !== 8'h00) begin errs++; $display("FAIL clr_prio_b got %h want 00", counts_b[23:16]); end
    endtask

    task automatic test_blank_window();
        logic [1:0] prev;
        int n_hi, n_lo;
        bit ok;
        ok = 1'b0;
        prev = digit_a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit_a != prev) begin ok = 1'b1; break; end
        end
        vec++; if (!ok) begin errs++; $display("FAIL blank_sync got timeout want digit change"); end
        for (int s = 0; s < 2; s++) begin
            prev = digit_a;
            n_hi = 0;
            n_lo = 0;
            while (blank_a === 1'b1 && digit_a == prev && n_hi < 40) begin n_hi++; @(negedge clk); end
            while (blank_a === 1'b0 && digit_a == prev && n_lo < 40) begin n_lo++; @(negedge clk); end
            vec++; if (n_hi != 2) begin errs++; $display("FAIL blank_hi slot %0d got %0d want 2", s, n_hi); end
            vec++; if (n_lo != 14) begin errs++; $display("FAIL blank_lo slot %0d got %0d want 14", s, n_lo); end
        end
    endtask

    task automatic test_paging();
        bit ok;
        int early, n23, lit;
        for (int i = 0; i < 3; i++) pulse(4'b0100, 4'b0000, 4'b0000);
        vec++; if (counts_d[23:16] !== 8'h03) begin errs++; $display("FAIL d_ch2 got %h want 03", counts_d[23:16]); end
        wait_digit(1, 1, 1'b0, ok);
        pulse_page();
        early = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (digit_d == 2'd0) begin ok = 1'b1; break; end
            if (page_d !== 1'b0) early++;
        end
        vec++; if (early != 0 || !ok) begin errs++; $display("FAIL page_early got %0d early ok=%0d want 0", early, ok); end
        vec++; if (page_d !== 1'b1) begin errs++; $display("FAIL page_adv got %0d want 1", page_d); end
        wait_digit(1, 0, 1'b1, ok);
        vec++; if (!ok || disp_d !== 4'd3) begin errs++; $display("FAIL page1_slot0 got %0d ok=%0d want 3", disp_d, ok); end
        wait_digit(1, 2, 1'b0, ok);
        n23 = 0;
        lit = 0;
        while (ok && digit_d >= 2'd2 && n23 < 100) begin
            n23++;
            if (blank_d !== 1'b1) lit++;
            @(negedge clk);
        end
        vec++; if (n23 != 32 || lit != 0) begin errs++; $display("FAIL empty_slots got %0d samples %0d lit want 32 0", n23, lit); end
        vec++; if (page_d !== 1'b1) begin errs++; $display("FAIL page_hold got %0d want 1", page_d); end
        pulse_page();
        pulse_page();
        wait_leave_d(0, ok);
        wait_digit(1, 0, 1'b0, ok);
        vec++; if (!ok || page_d !== 1'b0) begin errs++; $display("FAIL page_wrap got %0d ok=%0d want 0", page_d, ok); end
        wait_leave_d(0, ok);
        wait_digit(1, 0, 1'b0, ok);
        vec++; if (!ok || page_d !== 1'b0) begin errs++; $display("FAIL page_collapse got %0d ok=%0d want 0", page_d, ok); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n0;
        wait_digit(0, 2, 1'b1, ok);
        vec++; if (!ok) begin errs++; $display("FAIL pre_reset got timeout want digit 2"); end
        pulse_page();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        vec++; if (digit_a !== 2'd0 || disp_a !== 4'd0 || blank_a !== 1'b1) begin
            errs++; $display("FAIL async_scan got d=%0d n=%0d b=%b want 0 0 1", digit_a, disp_a, blank_a);
        end
        vec++; if (counts_a !== 32'h0 || counts_d !== 24'h0) begin
            errs++; $display("FAIL async_counts got %h %h want 0", counts_a, counts_d);
        end
        @(negedge clk);
        reset = 1'b0;
        n0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit_a != 2'd0) break;
            n0++;
        end
        vec++; if (n0 != 16 || digit_a !== 2'd1) begin errs++; $display("FAIL restart got %0d clocks digit %0d want 16 1", n0, digit_a); end
        wait_leave_d(0, ok);
        wait_digit(1, 0, 1'b0, ok);
        vec++; if (!ok || page_d !== 1'b0) begin errs++; $display("FAIL pend_discard got %0d ok=%0d want 0", page_d, ok); end
    endtask

    initial begin
        test_reset();
        test_bcd_count();
        test_wrap_sat();
        test_binary_prio();
        test_blank_window();
        test_paging();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
